// File: rtl/uart_pkg.sv
// Shared types and constants for the UART controller and its baud tick generator.
package uart_pkg;

  typedef enum logic [1:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_STOP} tx_state_t;
  typedef enum logic [1:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_STOP} rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned HALF_BIT   = 8;

  function automatic int unsigned cnt_width(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: counts 0..DIVISOR-1 and flags the terminal count as a tick.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = cnt_width(DIVISOR);
  localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

  if (DIVISOR < 1) begin : g_bad_divisor
    $error("uart_baud_tick: DIVISOR must be >= 1");
  end

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     cnt <= '0;
    else if (clear || cnt == LAST)  cnt <= '0;
    else                            cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_controller.sv
// 8N1 UART: independent transmit and receive engines with 16x oversampling.
module uart_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DIVISOR  = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_SEND,
  output logic       TX_STATUS,
  output logic       TX_END,
  output logic       UART_TX,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_END,
  output logic       RX_ERR
);

  // ---------------- transmit ----------------
  tx_state_t  tx_state, tx_next;
  logic [7:0] tx_shift;
  logic [2:0] tx_bit;
  logic [3:0] tx_os;
  logic       tx_tick, tx_accept, tx_bit_done, tx_end_q;

  assign tx_accept   = (tx_state == TXS_IDLE) && TX_SEND;
  assign tx_bit_done = tx_tick && (tx_os == 4'(OVERSAMPLE - 1));

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_tx_tick (
    .clk(clk), .reset(reset), .clear(tx_accept), .tick(tx_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= TXS_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TXS_IDLE:  if (TX_SEND)                       tx_next = TXS_START;
      TXS_START: if (tx_bit_done)                   tx_next = TXS_DATA;
      TXS_DATA:  if (tx_bit_done && tx_bit == 3'd7) tx_next = TXS_STOP;
      TXS_STOP:  if (tx_bit_done)                   tx_next = TXS_IDLE;
      default:                                      tx_next = TXS_IDLE;
    endcase
  end

  always_comb begin
    TX_STATUS = (tx_state == TXS_IDLE);
    case (tx_state)
      TXS_START: UART_TX = 1'b0;
      TXS_DATA:  UART_TX = tx_shift[0];
      default:   UART_TX = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_os    <= '0;
      tx_end_q <= 1'b0;
    end else begin
      tx_end_q <= (tx_state == TXS_STOP) && tx_bit_done;
      if (tx_accept) begin
        tx_shift <= TX_DATA;
        tx_bit   <= '0;
        tx_os    <= '0;
      end else if (tx_state != TXS_IDLE && tx_tick) begin
        tx_os <= tx_bit_done ? 4'd0 : tx_os + 4'd1;
        if (tx_state == TXS_DATA && tx_bit_done) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end
    end
  end

  assign TX_END = tx_end_q;

  // ---------------- receive ----------------
  rx_state_t  rx_state, rx_next;
  logic       rx_meta, rx_sync, rx_prev;
  logic [7:0] rx_shift, rx_data_q;
  logic [2:0] rx_bit;
  logic [3:0] rx_os;
  logic       rx_tick, rx_fall, rx_half_done, rx_bit_done;
  logic       rx_clear, rx_sample, rx_good, rx_bad, rx_end_q, rx_err_q;

  assign rx_fall      = rx_prev && !rx_sync;
  assign rx_half_done = rx_tick && (rx_os == 4'(HALF_BIT - 1));
  assign rx_bit_done  = rx_tick && (rx_os == 4'(OVERSAMPLE - 1));

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_rx_tick (
    .clk(clk), .reset(reset), .clear(rx_clear), .tick(rx_tick)
  );

  // rx_prev tracks the synchronised line in every state, so a line that stays
  // low after a framing error never looks like a fresh start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RXS_IDLE;
    end else begin
      rx_meta  <= UART_RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RXS_IDLE:  if (rx_fall)                        rx_next = RXS_START;
      RXS_START: if (rx_half_done)                   rx_next = rx_sync ? RXS_IDLE : RXS_DATA;
      RXS_DATA:  if (rx_bit_done && rx_bit == 3'd7)  rx_next = RXS_STOP;
      RXS_STOP:  if (rx_bit_done)                    rx_next = RXS_IDLE;
      default:                                       rx_next = RXS_IDLE;
    endcase
  end

  always_comb begin
    rx_clear  = (rx_state == RXS_IDLE) && rx_fall;
    rx_sample = (rx_state == RXS_DATA) && rx_bit_done;
    rx_good   = (rx_state == RXS_STOP) && rx_bit_done && rx_sync;
    rx_bad    = (rx_state == RXS_STOP) && rx_bit_done && !rx_sync;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift  <= '0;
      rx_data_q <= '0;
      rx_bit    <= '0;
      rx_os     <= '0;
      rx_end_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_end_q <= rx_good;
      rx_err_q <= rx_bad;
      if (rx_good) rx_data_q <= rx_shift;
      if (rx_clear) begin
        rx_os  <= '0;
        rx_bit <= '0;
      end else if (rx_state != RXS_IDLE && rx_tick) begin
        rx_os <= ((rx_state == RXS_START && rx_half_done) || rx_bit_done) ? 4'd0 : rx_os + 4'd1;
        if (rx_sample) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
      end
    end
  end

  assign RX_DATA = rx_data_q;
  assign RX_END  = rx_end_q;
  assign RX_ERR  = rx_err_q;

endmodule

// File: tb/tb_uart_controller.sv
// Directed self-checking bench for uart_controller with a 16-cycle bit time.
module tb_uart_controller;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] TX_DATA;
  logic       TX_SEND;
  logic       TX_STATUS, TX_END, UART_TX;
  logic [7:0] RX_DATA;
  logic       RX_END, RX_ERR;
  logic       rx_drv, loop_en;
  logic       rx_in;

  int total = 0;
  int bad   = 0;
  int cyc = 0;
  int rx_end_cnt = 0, rx_err_cnt = 0, tx_end_cnt = 0;
  int rx_end_at = 0, tx_end_at = 0;

  assign rx_in = loop_en ? UART_TX : rx_drv;

  uart_controller #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .reset(reset), .TX_DATA(TX_DATA), .TX_SEND(TX_SEND),
    .TX_STATUS(TX_STATUS), .TX_END(TX_END), .UART_TX(UART_TX),
    .UART_RX(rx_in), .RX_DATA(RX_DATA), .RX_END(RX_END), .RX_ERR(RX_ERR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (RX_END) begin rx_end_cnt <= rx_end_cnt + 1; rx_end_at <= cyc; end
      if (RX_ERR) rx_err_cnt <= rx_err_cnt + 1;
      if (TX_END) begin tx_end_cnt <= tx_end_cnt + 1; tx_end_at <= cyc; end
    end
  end

  // Expected line level for cycle c (1..160) of a frame carrying d.
  function automatic logic exp_tx(input logic [7:0] d, input int c);
    if (c <= 16)  return 1'b0;
    if (c <= 144) return d[(c - 17) / 16];
    return 1'b1;
  endfunction

  // Leaves the bench at cycle 1 of the frame (just after the accepting edge).
  task automatic start_send(input logic [7:0] d);
    @(negedge clk);
    TX_DATA = d;
    TX_SEND = 1'b1;
    @(posedge clk);
    #1;
    TX_SEND = 1'b0;
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    total++; if (UART_TX !== 1'b1)   begin bad++; $display("FAIL reset_uart_tx: got %b expected 1", UART_TX); end
    total++; if (TX_STATUS !== 1'b1) begin bad++; $display("FAIL reset_tx_status: got %b expected 1", TX_STATUS); end
    total++; if (TX_END !== 1'b0)    begin bad++; $display("FAIL reset_tx_end: got %b expected 0", TX_END); end
    total++; if (RX_DATA !== 8'h00)  begin bad++; $display("FAIL reset_rx_data: got %h expected 00", RX_DATA); end
    total++; if (RX_END !== 1'b0)    begin bad++; $display("FAIL reset_rx_end: got %b expected 0", RX_END); end
    total++; if (RX_ERR !== 1'b0)    begin bad++; $display("FAIL reset_rx_err: got %b expected 0", RX_ERR); end
  endtask

  task automatic test_tx_frame;
    start_send(8'h55);
    for (int c = 1; c <= 160; c++) begin
      total++; if (UART_TX !== exp_tx(8'h55, c)) begin bad++; $display("FAIL tx55_bit c=%0d: got %b expected %b", c, UART_TX, exp_tx(8'h55, c)); end
      total++; if (TX_STATUS !== 1'b0 || TX_END !== 1'b0) begin bad++; $display("FAIL tx55_busy c=%0d: status=%b end=%b expected 0/0", c, TX_STATUS, TX_END); end
      @(posedge clk); #1;
    end
    total++; if (TX_END !== 1'b1 || TX_STATUS !== 1'b1) begin bad++; $display("FAIL tx55_done: end=%b status=%b expected 1/1", TX_END, TX_STATUS); end
    @(posedge clk); #1;
    total++; if (TX_END !== 1'b0) begin bad++; $display("FAIL tx55_end_pulse: got %b expected 0", TX_END); end
  endtask

  task automatic test_busy_ignore;
    int base;
    base = tx_end_cnt;
    start_send(8'h0F);
    for (int c = 1; c <= 160; c++) begin
      if (c == 40) begin TX_DATA = 8'hFF; TX_SEND = 1'b1; end
      if (c == 41) TX_SEND = 1'b0;
      total++; if (UART_TX !== exp_tx(8'h0F, c)) begin bad++; $display("FAIL busy_bit c=%0d: got %b expected %b", c, UART_TX, exp_tx(8'h0F, c)); end
      @(posedge clk); #1;
    end
    repeat (40) @(posedge clk);
    #1;
    total++; if (tx_end_cnt - base !== 1) begin bad++; $display("FAIL busy_tx_end_count: got %0d expected 1", tx_end_cnt - base); end
    total++; if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin bad++; $display("FAIL busy_idle_after: tx=%b status=%b expected 1/1", UART_TX, TX_STATUS); end
  endtask

  task automatic test_back_to_back;
    start_send(8'h12);
    repeat (160) @(posedge clk);
    #1;
    total++; if (TX_STATUS !== 1'b1 || TX_END !== 1'b1) begin bad++; $display("FAIL b2b_ready: status=%b end=%b expected 1/1", TX_STATUS, TX_END); end
    TX_DATA = 8'hC3;
    TX_SEND = 1'b1;
    @(posedge clk); #1;
    TX_SEND = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      total++; if (UART_TX !== exp_tx(8'hC3, c)) begin bad++; $display("FAIL b2b_bit c=%0d: got %b expected %b", c, UART_TX, exp_tx(8'hC3, c)); end
      @(posedge clk); #1;
    end
    total++; if (TX_END !== 1'b1) begin bad++; $display("FAIL b2b_second_end: got %b expected 1", TX_END); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_loopback;
    int e0, r0, t0;
    loop_en = 1'b1;
    repeat (5) @(posedge clk);
    e0 = rx_err_cnt; r0 = rx_end_cnt; t0 = tx_end_cnt;
    start_send(8'hA5);
    repeat (175) @(posedge clk);
    #1;
    total++; if (rx_end_cnt - r0 !== 1) begin bad++; $display("FAIL loop_rx_end_count: got %0d expected 1", rx_end_cnt - r0); end
    total++; if (RX_DATA !== 8'hA5)     begin bad++; $display("FAIL loop_rx_data: got %h expected a5", RX_DATA); end
    total++; if (rx_err_cnt - e0 !== 0) begin bad++; $display("FAIL loop_rx_err: got %0d expected 0", rx_err_cnt - e0); end
    total++; if (tx_end_cnt - t0 !== 1) begin bad++; $display("FAIL loop_tx_end_count: got %0d expected 1", tx_end_cnt - t0); end
    total++; if (!(rx_end_at < tx_end_at)) begin bad++; $display("FAIL loop_order: rx_end at %0d tx_end at %0d, expected rx first", rx_end_at, tx_end_at); end
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_glitch;
    int e0, r0;
    e0 = rx_err_cnt; r0 = rx_end_cnt;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++; if (rx_end_cnt - r0 !== 0 || rx_err_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_pulses: end=%0d err=%0d expected 0/0", rx_end_cnt - r0, rx_err_cnt - e0); end
    total++; if (dut.rx_state !== RXS_IDLE) begin bad++; $display("FAIL glitch_idle: got %0d expected %0d", dut.rx_state, RXS_IDLE); end
    drive_rx_frame(8'h3C, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    total++; if (rx_end_cnt - r0 !== 1) begin bad++; $display("FAIL rx3c_end_count: got %0d expected 1", rx_end_cnt - r0); end
    total++; if (RX_DATA !== 8'h3C)     begin bad++; $display("FAIL rx3c_data: got %h expected 3c", RX_DATA); end
    total++; if (rx_err_cnt - e0 !== 0) begin bad++; $display("FAIL rx3c_err: got %0d expected 0", rx_err_cnt - e0); end
  endtask

  task automatic test_framing_error;
    int e0, r0;
    e0 = rx_err_cnt; r0 = rx_end_cnt;
    drive_rx_frame(8'h81, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    total++; if (rx_err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_err_count: got %0d expected 1", rx_err_cnt - e0); end
    total++; if (rx_end_cnt - r0 !== 0) begin bad++; $display("FAIL ferr_end_count: got %0d expected 0", rx_end_cnt - r0); end
    total++; if (RX_DATA !== 8'h3C)     begin bad++; $display("FAIL ferr_rx_data: got %h expected 3c", RX_DATA); end
    repeat (80) @(posedge clk);
    #1;
    total++; if (rx_err_cnt - e0 !== 1 || rx_end_cnt - r0 !== 0) begin bad++; $display("FAIL ferr_hold_low: err=%0d end=%0d expected 1/0", rx_err_cnt - e0, rx_end_cnt - r0); end
    rx_drv = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset_midframe;
    start_send(8'hF0);
    repeat (30) @(posedge clk);
    #1;
    total++; if (UART_TX !== 1'b0) begin bad++; $display("FAIL midrst_pre: got %b expected 0", UART_TX); end
    #1;
    reset = 1'b0;
    #1;
    total++; if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1 || TX_END !== 1'b0) begin bad++; $display("FAIL midrst_async: tx=%b status=%b end=%b expected 1/1/0", UART_TX, TX_STATUS, TX_END); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin bad++; $display("FAIL midrst_after: tx=%b status=%b expected 1/1", UART_TX, TX_STATUS); end
  endtask

  initial begin
    reset   = 1'b0;
    TX_DATA = 8'h00;
    TX_SEND = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    test_tx_frame;
    test_busy_ignore;
    test_back_to_back;
    test_loopback;
    test_glitch;
    test_framing_error;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_controller.md
# uart_controller

Serial-line controller that sequences the UART behind the memory-mapped peripheral block. It sits between that block and the board pins. It serialises the byte written to the transmit-data register into an 8N1 frame and deserialises incoming 8N1 frames into RX_DATA. It reports progress through TX_STATUS, TX_END and RX_END, the same status inputs the peripheral folds into its UART control register. Transmit and receive engines run independently and concurrently.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DIVISOR, CLK_FREQ/(BAUD*16) with integer truncation (651 at the defaults): clock cycles per oversample tick. Must be ≥1; elaboration fails otherwise.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- TX_DATA  in  8  byte to send; sampled only when a send is accepted.
- TX_SEND  in  1  one-cycle send request.
- TX_STATUS  out  1  1 = transmitter idle and able to accept a send.
- TX_END  out  1  one-cycle pulse when a frame's stop bit completes.
- UART_TX  out  1  serial output, idle high.
- UART_RX  in  1  serial input, asynchronous to clk.
- RX_DATA  out  8  last correctly framed byte received.
- RX_END  out  1  one-cycle pulse when a good frame completes.
- RX_ERR  out  1  one-cycle pulse on a framing error (stop bit = 0).

## Operation
- Frame format: start bit 0, D0 first through D7, then stop bit 1. Bit time is 16·DIVISOR cycles.
- Transmit FSM states and transitions:
  - IDLE: leaves to START when TX_SEND=1 and TX_STATUS=1. TX_DATA is latched on that edge.
  - START: goes to DATA after one bit time.
  - DATA: steps through 8 bits, one bit time each, then goes to STOP.
  - STOP: returns to IDLE after one bit time.
- TX_SEND while busy is ignored; the latched data is not modified.
- Receive path: UART_RX passes through a 2-flop synchroniser before any logic sees it.
- Receive FSM states and transitions:
  - IDLE: a synchronised 1→0 transition restarts the RX tick prescaler and moves to START.
  - START: after 8 ticks, samples the line. If 0, goes to DATA. If 1, treats it as a glitch and returns to IDLE with no outputs.
  - DATA: samples every 16 ticks, 8 times, shifting LSB first, then goes to STOP.
  - STOP: after 16 ticks, samples the stop bit.
    - If 1: RX_DATA is loaded and RX_END pulses.
    - If 0: RX_ERR pulses and RX_DATA is unchanged.
    - In both cases it returns to IDLE.
- A line held low after a framing error does not re-trigger reception. Re-arming needs a 1→0 edge.
- TX and RX share no state. Simultaneous activity on both is legal.

## Timing
- Reset values: UART_TX=1, TX_STATUS=1, TX_END=0, RX_DATA=8'h00, RX_END=0, RX_ERR=0. Both FSMs go to IDLE and the prescalers clear.
- Reset asserted mid-frame aborts the frame and drives UART_TX to 1 immediately.
- Transmit timing, with the send accepted at edge 0 and b = 16·DIVISOR:
  - TX_STATUS=0 and UART_TX=0 from cycle 1.
  - Start bit: cycles 1..b.
  - Data bit Dn: cycles b(n+1)+1 .. b(n+2).
  - Stop bit: cycles 9b+1 .. 10b.
  - At cycle 10b+1, TX_END=1 for one cycle and TX_STATUS=1.
- A TX_SEND in cycle 10b+1 is accepted, so back-to-back frames leave no idle gap.
- RX_END or RX_ERR is asserted in the cycle after the stop-bit sample, which falls mid-stop-bit. RX_DATA is valid in that same cycle.
- Tick counters count 0..DIVISOR-1 and wrap; a tick fires on the terminal count. Counter width is max(1, $clog2(DIVISOR)).

## Structure
- Package uart_pkg contains:
  - tx_state_t {IDLE, START, DATA, STOP}
  - rx_state_t {IDLE, START, DATA, STOP}
  - OVERSAMPLE = 16
  - HALF_BIT = 8
- Sub-module uart_baud_tick: parameterised by DIVISOR, with a synchronous clear input and a one-cycle tick output. It is instantiated once for TX (cleared on send accept) and once for RX (cleared on start-edge detect).

## Test plan
Unless a scenario says otherwise, use CLK_FREQ=1_600_000, BAUD=100_000, giving DIVISOR=1 and a 16-cycle bit.
- Reset: apply reset=0 with the lines idle → every output equals its listed reset value.
- TX 8'h55, send at edge 0 → UART_TX is 0 for cycles 1–16, then alternates 1,0,… per 16-cycle bit, stop bit high for cycles 145–160. TX_END pulse and TX_STATUS=1 at cycle 161.
- TX_SEND with 8'hFF while busy sending 8'h0F → the waveform carries only 8'h0F and exactly one TX_END pulse occurs.
- Loopback of UART_TX into UART_RX, send 8'hA5 → RX_DATA=8'hA5, one RX_END pulse before TX_END, RX_ERR stays 0.
- UART_RX low for 4 cycles then high → no RX_END, no RX_ERR, receiver back in IDLE. A following valid 8'h3C frame is received correctly.
- Frame 8'h81 with stop bit forced 0 → one RX_ERR pulse, no RX_END, RX_DATA keeps its prior value. Holding the line low afterwards produces no further pulses.
